board_supervisor: RTL and testbench
===================================

BOARD_SUPERVISOR -- requirements
Module: board_supervisor

Interface
REQ-001 SHALL have parameter NI, default 3: number of asynchronous board inputs (cwkey, ptt, exp_present), range 1..16.
REQ-002 SHALL have parameter DB_CYCLES, default 65536: debounce stability window in clk cycles, range 2..2^20.
REQ-003 SHALL have parameter RST_HOLD, default 1024: cycles core_rst is held after rst before lock is examined, range 1..2^16.
REQ-004 SHALL have parameter SETTLE, default 4096: cycles pll_locked must stay high before core release, range 1..2^16.
REQ-005 SHALL have parameter HB_DIV, default 36864000: heartbeat half-period in clk cycles (1 Hz at CLK_FREQ 73728000), range 2..2^27.
REQ-006 SHALL have port clk, input, 1: the single clock; all outputs are registered on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port raw_i, input, NI: asynchronous switch/key inputs.
REQ-009 SHALL have port pll_locked, input, 1: asynchronous PLL lock flag (IF_locked).
REQ-010 SHALL have port clean_o, output, NI: synchronised, debounced levels.
REQ-011 SHALL have ports rise_o and fall_o, output, NI each: one-cycle edge pulses of clean_o.
REQ-012 SHALL have port core_rst, output, 1: active-high reset for the downstream core.
REQ-013 SHALL have port state_o, output, 2: supervisor state encoding.
REQ-014 SHALL have port loss_cnt, output, 8: count of lock losses while in RUN.
REQ-015 SHALL have port heartbeat, output, 1: square-wave LED drive.

Function
REQ-016 SHALL pass each raw_i bit and pll_locked through a 2-flop synchroniser, with no logic between the flops.
REQ-017 SHALL give each input a counter that clears whenever the synchronised value equals clean_o[i] and increments otherwise.
REQ-018 SHALL load the synchronised value into clean_o[i] and clear the counter when the counter reaches DB_CYCLES-1 and the value still differs.
REQ-019 SHALL therefore change clean_o exactly DB_CYCLES+2 cycles after a step on raw_i that is then held stable.
REQ-020 SHALL ignore any glitch shorter than DB_CYCLES cycles; clean_o stays unchanged and the counter restarts.
REQ-021 SHALL assert rise_o[i] or fall_o[i] for exactly one cycle, in the same cycle clean_o[i] changes, and never both together.
REQ-022 SHALL implement the supervisor FSM states HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3, exposed on state_o.
REQ-023 SHALL go from HOLD to WAIT_LOCK after RST_HOLD cycles.
REQ-024 SHALL go from WAIT_LOCK to SETTLE when the synchronised lock is 1.
REQ-025 SHALL go from SETTLE to RUN after SETTLE consecutive locked cycles, and from SETTLE to WAIT_LOCK on lock loss with the settle counter cleared.
REQ-026 SHALL go from RUN to WAIT_LOCK on lock loss.
REQ-027 SHALL drive core_rst=1 in every state except RUN, as a registered output: core_rst falls in the first RUN cycle and rises in the first cycle after leaving RUN.
REQ-028 SHALL increment loss_cnt on each RUN->WAIT_LOCK transition, saturating at 255; it SHALL NOT count losses in SETTLE.
REQ-029 SHALL toggle heartbeat every HB_DIV cycles, driven by a free-running counter that wraps to 0 at HB_DIV-1.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set synchronisers, counters, clean_o, rise_o and fall_o to 0, state to HOLD, core_rst to 1, loss_cnt to 0 and heartbeat to 0.
REQ-031 SHALL apply rst asserted mid-operation (any state, mid-debounce) on the next edge with identical results; rst has priority over all other events.
REQ-032 SHALL ignore pll_locked while in HOLD.

Configuration
REQ-033 SHALL, when macro BOARD_SUPERVISOR_DEBOUNCE_EN is defined, implement REQ-017..REQ-020.
REQ-034 SHALL, when BOARD_SUPERVISOR_DEBOUNCE_EN is undefined, omit the debounce counters and make clean_o equal the synchroniser output, registered, giving 2-cycle latency; REQ-021 still applies.

Verification
REQ-035 SHALL cover: with macro on, DB_CYCLES=8, a raw_i[0] step 0->1 held -> clean_o[0]=1 and rise_o[0]=1 exactly 10 cycles later, for one cycle.
REQ-036 SHALL cover: with macro on, DB_CYCLES=8, a 5-cycle pulse on raw_i[1] -> clean_o[1] stays 0 and no pulses.
REQ-037 SHALL cover: with RST_HOLD=4, SETTLE=6 and pll_locked=1 from time 0 -> core_rst deasserts 11 cycles after rst falls, with state_o 0->1->2->3.
REQ-038 SHALL cover: in RUN, pll_locked dropped for 20 cycles 300 times -> loss_cnt saturates at 255 and core_rst=1 during each loss.
REQ-039 SHALL cover: in SETTLE, lock dropped at cycle 3 -> state returns to 1 and loss_cnt unchanged; a full SETTLE count then reaches RUN.
REQ-040 SHALL cover: with macro off, a raw_i step -> clean_o follows 2 cycles later; with HB_DIV=4, heartbeat period is 8 cycles.

Source files
------------

// File: rtl/board_supervisor.sv
// board_supervisor: conditions asynchronous board inputs (synchronise, optional
// debounce, edge pulses) and sequences the downstream core reset from the PLL
// lock flag, counting lock losses and driving a heartbeat LED.
// Optional debounce filter: define BOARD_SUPERVISOR_DEBOUNCE_EN. Without it,
// clean_o is the second synchroniser flop (2-cycle latency).
module board_supervisor #(
  parameter int NI        = 3,
  parameter int DB_CYCLES = 65536,
  parameter int RST_HOLD  = 1024,
  parameter int SETTLE    = 4096,
  parameter int HB_DIV    = 36864000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NI-1:0] raw_i,
  input  logic          pll_locked,
  output logic [NI-1:0] clean_o,
  output logic [NI-1:0] rise_o,
  output logic [NI-1:0] fall_o,
  output logic          core_rst,
  output logic [1:0]    state_o,
  output logic [7:0]    loss_cnt,
  output logic          heartbeat
);

  localparam int TW = 17;
  localparam int HW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [TW-1:0] HOLD_MAX   = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] SETTLE_MAX = TW'(SETTLE - 1);
  localparam logic [HW-1:0] HB_MAX     = HW'(HB_DIV - 1);

  logic [NI-1:0] sync1_q, sync1_d;
  logic [NI-1:0] clean_q, clean_d;
  logic [NI-1:0] rise_q, rise_d;
  logic [NI-1:0] fall_q, fall_d;

`ifdef BOARD_SUPERVISOR_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

  logic [NI-1:0]         sync2_q, sync2_d;
  logic [NI-1:0][CW-1:0] cnt_q, cnt_d;

  // Debounce: count consecutive cycles the synchronised level disagrees with
  // the clean level; adopt the new level once it has disagreed DB_CYCLES times.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NI; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  // Synchroniser, debounce counter and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
`else
  // Without debounce the clean register is the second synchroniser stage;
  // edge pulses are derived from the value about to be loaded into it.
  always_comb begin
    sync1_d = raw_i;
    clean_d = sync1_q;
    rise_d  = clean_d & ~clean_q;
    fall_d  = ~clean_d & clean_q;
  end

  // Two-flop synchroniser and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
`endif

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          lock1_q, lock1_d;
  logic          lock2_q, lock2_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    loss_q, loss_d;
  logic          core_rst_q, core_rst_d;
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic          hb_q, hb_d;

  // Supervisor next state: hold off, wait for lock, require a stable locked
  // window, then run; any lock loss falls back to waiting for lock.
  always_comb begin
    lock1_d = pll_locked;
    lock2_d = lock1_q;
    state_d = state_q;
    tmr_d   = tmr_q;
    loss_d  = loss_q;
    case (state_q)
      S_HOLD: begin
        // Lock is deliberately not looked at while holding.
        if (tmr_q == HOLD_MAX) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        tmr_d = '0;
        if (lock2_q) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!lock2_q) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == SETTLE_MAX) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        tmr_d = '0;
        if (!lock2_q) begin
          state_d = S_WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
    endcase
    // Registered from the next state so core_rst lines up with state_o.
    core_rst_d = (state_d != S_RUN);
  end

  // Free-running heartbeat divider; toggles the LED on each wrap.
  always_comb begin
    hb_cnt_d = hb_cnt_q + HW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_MAX) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  // Lock synchroniser, supervisor and heartbeat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock1_q    <= 1'b0;
      lock2_q    <= 1'b0;
      state_q    <= S_HOLD;
      tmr_q      <= '0;
      loss_q     <= '0;
      core_rst_q <= 1'b1;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
    end else begin
      lock1_q    <= lock1_d;
      lock2_q    <= lock2_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      loss_q     <= loss_d;
      core_rst_q <= core_rst_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
    end
  end

  assign clean_o   = clean_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign core_rst  = core_rst_q;
  assign state_o   = state_q;
  assign loss_cnt  = loss_q;
  assign heartbeat = hb_q;

endmodule

// File: tb/tb_board_supervisor.sv
// Self-checking bench for board_supervisor: power-up sequence table, directed
// debounce/glitch/reset/settle/saturation sequences, then random stimulus
// checked every cycle against a behavioural model.
module tb_board_supervisor;

  localparam int NI = 3;
  localparam int DB = 8;
  localparam int RH = 4;
  localparam int ST = 6;
  localparam int HB = 4;
`ifdef BOARD_SUPERVISOR_DEBOUNCE_EN
  localparam bit DBE = 1'b1;
`else
  localparam bit DBE = 1'b0;
`endif
  localparam int LAT = DBE ? DB + 2 : 2;
  localparam int HD  = DB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] raw_i;
  logic          pll_locked;
  logic [NI-1:0] clean_o, rise_o, fall_o;
  logic          core_rst;
  logic [1:0]    state_o;
  logic [7:0]    loss_cnt;
  logic          heartbeat;

  board_supervisor #(
    .NI(NI), .DB_CYCLES(DB), .RST_HOLD(RH), .SETTLE(ST), .HB_DIV(HB)
  ) dut (
    .clk(clk), .rst(rst), .raw_i(raw_i), .pll_locked(pll_locked),
    .clean_o(clean_o), .rise_o(rise_o), .fall_o(fall_o),
    .core_rst(core_rst), .state_o(state_o), .loss_cnt(loss_cnt),
    .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state_o !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, state_o, s);
  endtask

  // Behavioural model. History arrays hold samples per clock edge, newest at
  // index 0; the design's two synchroniser stages mean a level sampled at edge
  // n-2 is what the filter and supervisor act on at edge n.
  logic [NI-1:0] m_h [HD];
  logic          m_lk [3];
  int            m_state = 0, m_t = 0, m_loss = 0, m_since = 0;
  logic [NI-1:0] m_clean = '0, m_rise = '0, m_fall = '0;

  always @(posedge clk) begin : model
    logic [NI-1:0] prev;
    logic          lock_s, same;
    if (rst) begin
      for (int j = 0; j < HD; j++) m_h[j] = '0;
      for (int j = 0; j < 3; j++) m_lk[j] = 1'b0;
      m_clean = '0; m_rise = '0; m_fall = '0;
      m_state = 0; m_t = 0; m_loss = 0; m_since = 0;
    end else begin
      for (int j = HD - 1; j > 0; j--) m_h[j] = m_h[j-1];
      m_h[0] = raw_i;
      m_lk[2] = m_lk[1]; m_lk[1] = m_lk[0]; m_lk[0] = pll_locked;
      lock_s = m_lk[2];
      prev = m_clean;
`ifdef BOARD_SUPERVISOR_DEBOUNCE_EN
      // A new level is adopted once the last DB filtered samples all agree.
      for (int i = 0; i < NI; i++) begin
        same = 1'b1;
        for (int j = 3; j < HD; j++) if (m_h[j][i] != m_h[2][i]) same = 1'b0;
        if (same) m_clean[i] = m_h[2][i];
      end
`else
      m_clean = m_h[1];
`endif
      m_rise = m_clean & ~prev;
      m_fall = ~m_clean & prev;
      m_since++;
      case (m_state)
        0: begin
          m_t++;
          if (m_t == RH) begin m_state = 1; m_t = 0; end
        end
        1: if (lock_s) begin m_state = 2; m_t = 0; end
        2: begin
          if (!lock_s) m_state = 1;
          else begin
            m_t++;
            if (m_t == ST) m_state = 3;
          end
        end
        default: if (!lock_s) begin
          m_state = 1;
          if (m_loss < 255) m_loss++;
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_clean", clean_o, m_clean);
      chk("mdl_rise", rise_o, m_rise);
      chk("mdl_fall", fall_o, m_fall);
      chk("mdl_state", state_o, m_state);
      chk("mdl_core_rst", core_rst, (m_state != 3));
      chk("mdl_loss", loss_cnt, m_loss);
      chk("mdl_hb", heartbeat, (m_since / HB) % 2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       lock;
    logic [1:0] st;
    logic       core;
    logic       hb;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int len;
    int n;
    logic [7:0] loss0;

    // Power-up sequence after rst release, one entry per clock edge.
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 1'b1};

    rst = 1'b1; pll_locked = 1'b1; raw_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_core", core_rst, 1);
    chk("rst_clean", clean_o, 0);
    chk("rst_rise", rise_o, 0);
    chk("rst_fall", fall_o, 0);
    chk("rst_loss", loss_cnt, 0);
    chk("rst_hb", heartbeat, 0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      pll_locked = tbl[k].lock;
      @(negedge clk);
      chk("seq_state", state_o, tbl[k].st);
      chk("seq_core_rst", core_rst, tbl[k].core);
      chk("seq_hb", heartbeat, tbl[k].hb);
    end

    // Held step on raw_i[0], both directions.
    raw_i[0] = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      chk("step_clean", clean_o[0], (k >= LAT));
      chk("step_rise", rise_o[0], (k == LAT));
      chk("step_fall", fall_o[0], 0);
    end
    raw_i[0] = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      chk("fstep_clean", clean_o[0], (k < LAT));
      chk("fstep_fall", fall_o[0], (k == LAT));
      chk("fstep_rise", rise_o[0], 0);
    end

    // 5-cycle pulse on raw_i[1]: filtered out with debounce, passed without.
    raw_i[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("glitch_clean", clean_o[1], (!DBE) && k >= 2 && k <= 6);
      chk("glitch_rise", rise_o[1], (!DBE) && k == 2);
      chk("glitch_fall", fall_o[1], (!DBE) && k == 7);
      if (k == 5) raw_i[1] = 1'b0;
    end

    // Reset in RUN while raw_i[2] is mid-debounce.
    raw_i[2] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_state", state_o, 0);
    chk("mrst_core", core_rst, 1);
    chk("mrst_clean", clean_o, 0);
    chk("mrst_loss", loss_cnt, 0);
    chk("mrst_hb", heartbeat, 0);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("mrst_reclean", clean_o[2], (k >= LAT));
    end
    wait_state(2'd3, 30, "mrst_run");

    // Lock loss from RUN, then a loss early in SETTLE that must not count.
    pll_locked = 1'b0;
    wait_state(2'd1, 10, "loss_wait");
    chk("loss_core", core_rst, 1);
    chk("loss_cnt1", loss_cnt, 1);
    loss0 = loss_cnt;
    pll_locked = 1'b1;
    wait_state(2'd2, 10, "settle_enter");
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    wait_state(2'd1, 10, "settle_drop");
    chk("settle_loss", loss_cnt, loss0);
    pll_locked = 1'b1;
    wait_state(2'd2, 10, "settle_reenter");
    n = 0;
    while (state_o !== 2'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("settle_len", n, ST);
    chk("settle_core", core_rst, 0);
    chk("settle_loss2", loss_cnt, loss0);

    // 300 lock losses in RUN: counter saturates.
    for (int r = 0; r < 300; r++) begin
      pll_locked = 1'b0;
      repeat (20) @(negedge clk);
      chk("sat_core", core_rst, 1);
      pll_locked = 1'b1;
      wait_state(2'd3, 20, "sat_run");
    end
    chk("sat_loss", loss_cnt, 255);

    // Random segments of inputs, lock and occasional reset.
    for (int s = 0; s < 250; s++) begin
      len = $urandom_range(1, 20);
      raw_i = NI'($urandom);
      pll_locked = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 30) == 0);
      repeat (len) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
